// File: rtl/prog_loader.sv
// ---------------------------------------------------------------------------
// prog_loader
//
// Loads a program image into the RISC_V core's instruction memory from a
// valid/ready word stream. The image is written sequentially from address 0.
// Every entry the stream does not cover is padded with NOP_WORD. The core is
// held in reset until the image is complete, then released. A start pulse in
// IDLE or RUN begins a new load, so the core can be reloaded at run time.
//
// Parameters:
//   XLEN      instruction/data word width
//   DEPTH     instruction memory entries (power of two, >= 2)
//   AW        memory address width, derived from DEPTH
//   NOP_WORD  pad word (ADDI x0,x0,0)
//   RST_HOLD  cycles core_rst stays high after the image is complete (>= 1)
//
// Ports:
//   clk           clock, all logic on the rising edge
//   rst           synchronous active-high reset
//   start         one-cycle pulse, begins a load (honoured in IDLE and RUN)
//   in_valid      input word valid
//   in_ready      loader accepts a word (high only while loading)
//   in_data       instruction word
//   in_last       marks the final word of the image
//   mem_we        instruction memory write enable (registered)
//   mem_addr      instruction memory write address (registered)
//   mem_wdata     instruction memory write data (registered)
//   core_rst      active-high reset to the core (registered)
//   done          image loaded and core running (registered)
//   overflow      the stream ran past DEPTH words without in_last
//   words_loaded  number of input words accepted in the current load
//
// Optional feature, enabled by defining PROG_LOADER_CHECKSUM_EN:
//   exp_sum       expected XOR of all accepted input words
//   sum_err       the XOR of the loaded image did not match exp_sum; the core
//                 stays in reset until the next start or rst
// ---------------------------------------------------------------------------
module prog_loader #(
   parameter int               XLEN     = 32,
   parameter int               DEPTH    = 256,
   parameter int               AW       = $clog2(DEPTH),
   parameter logic [XLEN-1:0]  NOP_WORD = XLEN'(32'h00000013),
   parameter int               RST_HOLD = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   in_data,
   input  logic              in_last,
   output logic              mem_we,
   output logic [AW-1:0]     mem_addr,
   output logic [XLEN-1:0]   mem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              overflow,
   output logic [AW:0]       words_loaded
`ifdef PROG_LOADER_CHECKSUM_EN
   ,
   input  logic [XLEN-1:0]   exp_sum,
   output logic              sum_err
`endif
);

   // The hold counter only has to reach RST_HOLD-1.
   localparam int HW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
   localparam logic [AW-1:0] PTR_ONE   = AW'(1);
   localparam logic [AW:0]   WL_ONE    = (AW + 1)'(1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD - 1);
   localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_FILL,
      ST_HOLD,
      ST_RUN
   } state_t;

   state_t          state, state_nx;
   logic [AW-1:0]   ptr, ptr_nx;
   logic [HW-1:0]   hold_cnt, hold_nx;
   logic [AW:0]     wl_nx;
   logic            ovf_nx;
   logic            we_nx;
   logic [AW-1:0]   addr_nx;
   logic [XLEN-1:0] wdata_nx;
   logic            core_rst_nx;
   logic            done_nx;
   logic            begin_load;

`ifdef PROG_LOADER_CHECKSUM_EN
   logic [XLEN-1:0] sum, sum_nx;
   logic            err_nx;
`endif

   // in_ready is a pure decode of the state register, so the upstream source
   // never sees a combinational path from its own in_valid.
   assign in_ready = (state == ST_LOAD);

   // Next-state and next-output logic. Every registered value, including the
   // memory write port and core_rst/done, is computed here and then captured
   // by the register block, so all outputs are glitch-free.
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      hold_nx  = hold_cnt;
      wl_nx    = words_loaded;
      ovf_nx   = overflow;
      we_nx    = 1'b0;
      addr_nx  = mem_addr;
      wdata_nx = mem_wdata;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum_nx   = sum;
      err_nx   = sum_err;
`endif

      // A new load may begin from IDLE or RUN, and additionally from a HOLD
      // that is parked on a checksum error.
      begin_load = start && ((state == ST_IDLE) || (state == ST_RUN));
`ifdef PROG_LOADER_CHECKSUM_EN
      if (start && (state == ST_HOLD) && sum_err) begin
         begin_load = 1'b1;
      end
`endif

      unique case (state)
         ST_IDLE: begin
         end

         ST_LOAD: begin
            if (in_valid && in_ready) begin
               we_nx    = 1'b1;
               addr_nx  = ptr;
               wdata_nx = in_data;
               wl_nx    = words_loaded + WL_ONE;
`ifdef PROG_LOADER_CHECKSUM_EN
               sum_nx   = sum ^ in_data;
`endif
               if (ptr == LAST_ADDR) begin
                  // Memory is full. Anything beyond this beat is dropped, and
                  // a missing in_last here means the image was too long.
                  state_nx = ST_HOLD;
                  hold_nx  = '0;
                  if (!in_last) begin
                     ovf_nx = 1'b1;
                  end
               end else if (in_last) begin
                  state_nx = ST_FILL;
                  ptr_nx   = ptr + PTR_ONE;
               end else begin
                  ptr_nx   = ptr + PTR_ONE;
               end
            end
         end

         ST_FILL: begin
            // One pad write per cycle, no gaps, until the last entry.
            we_nx    = 1'b1;
            addr_nx  = ptr;
            wdata_nx = NOP_WORD;
            if (ptr == LAST_ADDR) begin
               state_nx = ST_HOLD;
               hold_nx  = '0;
            end else begin
               ptr_nx   = ptr + PTR_ONE;
            end
         end

         ST_HOLD: begin
`ifdef PROG_LOADER_CHECKSUM_EN
            // The running sum already includes the final beat when HOLD is
            // entered, so the comparison is made on the first HOLD cycle.
            // On a mismatch the counter freezes and the core stays in reset.
            if (sum_err) begin
               hold_nx = hold_cnt;
            end else if ((hold_cnt == '0) && (sum != exp_sum)) begin
               err_nx = 1'b1;
            end else if (hold_cnt == HOLD_LAST) begin
               state_nx = ST_RUN;
            end else begin
               hold_nx = hold_cnt + HOLD_ONE;
            end
`else
            if (hold_cnt == HOLD_LAST) begin
               state_nx = ST_RUN;
            end else begin
               hold_nx = hold_cnt + HOLD_ONE;
            end
`endif
         end

         ST_RUN: begin
         end

         default: begin
            state_nx = ST_IDLE;
         end
      endcase

      // Starting a load wipes the per-load bookkeeping; memory contents are
      // simply overwritten by the new image.
      if (begin_load) begin
         state_nx = ST_LOAD;
         ptr_nx   = '0;
         wl_nx    = '0;
         ovf_nx   = 1'b0;
         hold_nx  = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
         sum_nx   = '0;
         err_nx   = 1'b0;
`endif
      end

      // The core only runs in RUN; deriving these from the next state makes
      // core_rst rise in the same cycle the loader leaves RUN.
      core_rst_nx = (state_nx != ST_RUN);
      done_nx     = (state_nx == ST_RUN);
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         ptr          <= '0;
         hold_cnt     <= '0;
         words_loaded <= '0;
         overflow     <= 1'b0;
         mem_we       <= 1'b0;
         mem_addr     <= '0;
         mem_wdata    <= '0;
         core_rst     <= 1'b1;
         done         <= 1'b0;
      end else begin
         state        <= state_nx;
         ptr          <= ptr_nx;
         hold_cnt     <= hold_nx;
         words_loaded <= wl_nx;
         overflow     <= ovf_nx;
         mem_we       <= we_nx;
         mem_addr     <= addr_nx;
         mem_wdata    <= wdata_nx;
         core_rst     <= core_rst_nx;
         done         <= done_nx;
      end
   end

`ifdef PROG_LOADER_CHECKSUM_EN
   // Running XOR of accepted words and the sticky checksum error flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         sum     <= '0;
         sum_err <= 1'b0;
      end else begin
         sum     <= sum_nx;
         sum_err <= err_nx;
      end
   end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------------------
// tb_prog_loader
//
// Directed testbench for prog_loader with the default parameters (XLEN=32,
// DEPTH=256, RST_HOLD=4). A monitor logs every memory write and every input
// handshake, together with the cycle it happened in. The directed sequences
// then compare that log against hand-derived expectations: a contiguous
// image, NOP padding, release timing, overflow and reset behaviour. The
// checksum sequence is compiled in only when PROG_LOADER_CHECKSUM_EN is set.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_prog_loader;

   localparam logic [31:0] NOP = 32'h00000013;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        in_last = 1'b0;
   logic        mem_we;
   logic [7:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic        core_rst;
   logic        done;
   logic        overflow;
   logic [8:0]  words_loaded;
`ifdef PROG_LOADER_CHECKSUM_EN
   logic [31:0] exp_sum = '0;
   logic        sum_err;
`endif

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   logic [31:0] stim [0:299];

   int          wr_addr [$];
   logic [31:0] wr_data [$];
   int          wr_cyc  [$];
   int          hs_cyc  [$];
   int          w255_cyc = -1;
   int          rel_cyc  = -1;
   logic        prev_core_rst = 1'b1;

   prog_loader dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .core_rst     (core_rst),
      .done         (done),
      .overflow     (overflow),
      .words_loaded (words_loaded)
`ifdef PROG_LOADER_CHECKSUM_EN
      ,
      .exp_sum      (exp_sum),
      .sum_err      (sum_err)
`endif
   );

   // 10 ns clock and a free-running cycle counter.
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
   end

   // Write/handshake monitor, sampled on the falling edge. A handshake seen
   // here completes on the next rising edge, so its write must show up on
   // the following falling edge, i.e. at cyc+1.
   always @(negedge clk) begin
      if (mem_we === 1'b1) begin
         wr_addr.push_back(int'(mem_addr));
         wr_data.push_back(mem_wdata);
         wr_cyc.push_back(cyc);
         if (mem_addr == 8'hFF) begin
            w255_cyc = cyc;
         end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
         hs_cyc.push_back(cyc + 1);
      end
      if (prev_core_rst === 1'b1 && core_rst === 1'b0) begin
         rel_cyc = cyc;
      end
      prev_core_rst = core_rst;
   end

   // Safety net in case something stalls.
   initial begin
      #500us;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clear_log();
      wr_addr.delete();
      wr_data.delete();
      wr_cyc.delete();
      hs_cyc.delete();
      w255_cyc = -1;
      rel_cyc  = -1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   // Streams stim[0..n-1]. With gappy set, in_valid is low every other
   // cycle. Stops early once in_ready drops after at least one accepted word.
   task automatic applyStimulus(input int n, input int last_idx, input bit gappy, output int accepted);
      int idx   = 0;
      int guard = 0;
      bit phase = 1'b0;
      bit rdy;
      while (idx < n && guard < 2000) begin
         rdy = in_ready;
         if (!rdy && idx > 0) break;
         in_valid = gappy ? phase : 1'b1;
         phase    = ~phase;
         in_data  = stim[idx];
         in_last  = (idx == last_idx);
         tick(1);
         if (in_valid && rdy) idx++;
         guard++;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      accepted = idx;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int k = 0;
      while (done !== 1'b1 && k < budget) begin
         tick(1);
         k++;
      end
      if (done !== 1'b1) begin
         checkOutput(tag, 32'd0, 32'd1);
      end
      tick(1);
   endtask

   // Checks the logged writes: addresses count up from 0, data words first
   // and NOPs after, data writes one cycle after their handshake, pad writes
   // back to back.
   task automatic check_image(input string tag, input int n_data, input int n_total, input bit exact);
      if (exact) begin
         checkOutput({tag, "_wr_count"}, wr_addr.size(), n_total);
         checkOutput({tag, "_hs_count"}, hs_cyc.size(), n_data);
      end
      for (int i = 0; i < wr_addr.size(); i++) begin
         checkOutput($sformatf("%s_addr%0d", tag, i), wr_addr[i], i);
         checkOutput($sformatf("%s_data%0d", tag, i), wr_data[i], (i < n_data) ? stim[i] : NOP);
         if (i < n_data && i < hs_cyc.size()) begin
            checkOutput($sformatf("%s_wcyc%0d", tag, i), wr_cyc[i], hs_cyc[i]);
         end else if (i >= n_data && i > 0) begin
            checkOutput($sformatf("%s_gap%0d", tag, i), wr_cyc[i], wr_cyc[i-1] + 1);
         end
      end
   endtask

   task automatic check_reset_values(input string tag);
      checkOutput({tag, "_core_rst"}, core_rst, 1);
      checkOutput({tag, "_in_ready"}, in_ready, 0);
      checkOutput({tag, "_done"}, done, 0);
      checkOutput({tag, "_mem_we"}, mem_we, 0);
      checkOutput({tag, "_mem_addr"}, mem_addr, 0);
      checkOutput({tag, "_mem_wdata"}, mem_wdata, 0);
      checkOutput({tag, "_overflow"}, overflow, 0);
      checkOutput({tag, "_words"}, words_loaded, 0);
   endtask

   initial begin
      int acc;
      int bad;
      int n;

      stim[0] = 32'h00A00113;
      for (int i = 1; i < 300; i++) begin
         stim[i] = 32'hA0000000 | i;
      end

      // Reset for 5 cycles, then idle without start.
      $display("[TB] reset and idle");
      tick(5);
      check_reset_values("rst");
      rst = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         if (core_rst !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0 || mem_we !== 1'b0) bad++;
      end
      checkOutput("idle_stable", bad, 0);

      // 19-word image, in_valid always high.
      $display("[TB] 19-word image, continuous");
      clear_log();
      pulse_start();
      checkOutput("t2_ready", in_ready, 1);
      applyStimulus(19, 18, 1'b0, acc);
      checkOutput("t2_accepted", acc, 19);
      wait_done("t2_done_timeout", 400);
      check_image("t2", 19, 256, 1'b1);
      checkOutput("t2_release", rel_cyc - w255_cyc, 4);
      checkOutput("t2_words", words_loaded, 19);
      checkOutput("t2_overflow", overflow, 0);
      checkOutput("t2_core_rst", core_rst, 0);

      // Same image, in_valid toggling; reload starts from RUN.
      $display("[TB] 19-word image, gappy");
      clear_log();
      pulse_start();
      checkOutput("t3_core_rst", core_rst, 1);
      checkOutput("t3_done", done, 0);
      checkOutput("t3_words_clr", words_loaded, 0);
      applyStimulus(19, 18, 1'b1, acc);
      checkOutput("t3_accepted", acc, 19);
      wait_done("t3_done_timeout", 400);
      check_image("t3", 19, 256, 1'b1);
      checkOutput("t3_release", rel_cyc - w255_cyc, 4);
      checkOutput("t3_words", words_loaded, 19);

      // 300 words without in_last: overflow after 256.
      $display("[TB] overflow");
      clear_log();
      pulse_start();
      applyStimulus(300, -1, 1'b0, acc);
      checkOutput("t4_accepted", acc, 256);
      checkOutput("t4_ready_low", in_ready, 0);
      wait_done("t4_done_timeout", 100);
      check_image("t4", 256, 256, 1'b1);
      checkOutput("t4_overflow", overflow, 1);
      checkOutput("t4_words", words_loaded, 256);
      checkOutput("t4_release", rel_cyc - w255_cyc, 4);

      // Reload from RUN with 3 words, then reset in the middle of FILL.
      $display("[TB] reload and reset mid-fill");
      clear_log();
      pulse_start();
      checkOutput("t5_core_rst", core_rst, 1);
      checkOutput("t5_done", done, 0);
      checkOutput("t5_overflow_clr", overflow, 0);
      applyStimulus(3, 2, 1'b0, acc);
      checkOutput("t5_accepted", acc, 3);
      tick(50);
      checkOutput("t5_partial", (wr_addr.size() > 40 && wr_addr.size() < 256) ? 32'd1 : 32'd0, 32'd1);
      check_image("t5", 3, 0, 1'b0);
      rst = 1'b1;
      tick(1);
      check_reset_values("t5_rst");
      rst = 1'b0;
      n = wr_addr.size();
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (core_rst !== 1'b1 || in_ready !== 1'b0 || done !== 1'b0) bad++;
      end
      checkOutput("t5_no_writes", wr_addr.size(), n);
      checkOutput("t5_idle", bad, 0);

`ifdef PROG_LOADER_CHECKSUM_EN
      // Checksum match and mismatch.
      $display("[TB] checksum");
      stim[0] = 32'h1;
      stim[1] = 32'h2;
      stim[2] = 32'h4;
      exp_sum = 32'h7;
      pulse_start();
      applyStimulus(3, 2, 1'b0, acc);
      wait_done("cs_ok_timeout", 400);
      checkOutput("cs_ok_err", sum_err, 0);
      checkOutput("cs_ok_done", done, 1);
      exp_sum = 32'h6;
      pulse_start();
      applyStimulus(3, 2, 1'b0, acc);
      tick(300);
      checkOutput("cs_bad_err", sum_err, 1);
      checkOutput("cs_bad_done", done, 0);
      bad = 0;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (core_rst !== 1'b1) bad++;
      end
      checkOutput("cs_bad_held", bad, 0);
      pulse_start();
      checkOutput("cs_restart_err", sum_err, 0);
      checkOutput("cs_restart_ready", in_ready, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Parametrised program loader for the RISC_V core's instruction memory. Replaces hard-coded per-index instruction initialisation.
- Accepts a stream of instruction words over a valid/ready port and writes them sequentially from address 0.
- Pads every unwritten entry with a NOP.
- Holds the core in reset until the image is complete, then releases it. Supports re-load at run time.

Parameters:
- XLEN, 32, instruction/data word width.
- DEPTH, 256, instruction memory entries; must be a power of two, >= 2.
- AW, $clog2(DEPTH), memory address width (derived).
- NOP_WORD, 32'h00000013, pad word (ADDI x0,x0,0).
- RST_HOLD, 4, cycles core_rst stays high after the image is complete; must be >= 1.

Ports:
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a load (honoured in IDLE and RUN only)
- in_valid  in  1  input word valid
- in_ready  out  1  loader accepts word (high only in LOAD)
- in_data  in  XLEN  instruction word
- in_last  in  1  marks final word of image
- mem_we  out  1  instruction memory write enable
- mem_addr  out  AW  write address
- mem_wdata  out  XLEN  write data
- core_rst  out  1  reset to RISC_V core, active-high
- done  out  1  image loaded, core running
- overflow  out  1  image exceeded DEPTH
- words_loaded  out  AW+1  count of accepted input words

Behaviour:
- Reset values: state IDLE, core_rst=1, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, done=0, overflow=0, words_loaded=0; internal ptr=0, hold counter=0.
- in_ready is decoded from state only (state==LOAD); it has no combinational path from in_valid.
- mem_we/mem_addr/mem_wdata are registered: a write appears one cycle after the accepting handshake or fill step.
- States:
  - IDLE:
    - core_rst=1, done=0.
    - start -> LOAD with ptr=0, words_loaded=0, overflow=0.
  - LOAD:
    - On in_valid&&in_ready: write in_data at ptr, words_loaded++.
    - Beat with ptr==DEPTH-1: -> HOLD. Additionally, if in_last=0 on that beat, set overflow=1.
    - Beat with in_last=1 and ptr<DEPTH-1: -> FILL with ptr+1.
    - Any other accepted beat: ptr++, stay in LOAD.
    - No handshake: hold state and ptr; mem_we=0.
  - FILL:
    - Each cycle write NOP_WORD at ptr.
    - ptr==DEPTH-1: -> HOLD; else ptr++.
    - Fill length = DEPTH - words_loaded cycles, with no gaps.
  - HOLD:
    - core_rst=1.
    - Counter counts RST_HOLD cycles, then -> RUN.
  - RUN:
    - core_rst=0, done=1.
    - start -> LOAD: core_rst=1 and done=0 in the next cycle; ptr, words_loaded, and overflow are cleared.
- start is ignored in LOAD, FILL, and HOLD.
- core_rst and done are registered and never glitch.
- rst mid-load: immediate return to reset values next edge. Memory contents already written are not cleared; a new start is required.
- Zero-length image is impossible: the first accepted beat is always written.
- ptr wraps are never exercised; the state machine exits at DEPTH-1.

Optional Feature:
- PROG_LOADER_CHECKSUM_EN
  - Defined:
    - Adds input exp_sum (XLEN) and output sum_err (1, reset 0).
    - Keeps a running XOR of accepted in_data words (pad words excluded); the sum is cleared on start.
    - On HOLD entry, compare the sum with exp_sum. Mismatch: sum_err=1, remain in HOLD with core_rst=1 until start (-> LOAD, sum_err cleared) or rst.
  - Undefined: ports absent; HOLD always proceeds to RUN.

Test Plan:
- Reset with rst=1 for 5 cycles, then release -> core_rst=1, in_ready=0, done=0, mem_we=0 throughout; no state change without start.
- start, stream 19 words (word 0 = 32'h00A00113, in_last on word 18), in_valid always high -> 19 writes to addr 0..18 with matching data; then 237 NOP_WORD writes to addr 19..255; core_rst falls exactly 4 cycles after the addr-255 write; done=1, words_loaded=19.
- Same 19-word stream with in_valid deasserted every other cycle -> identical memory image and addresses; no write occurs in cycles without a handshake.
- Stream 300 words with no in_last -> 256 writes (addr 0..255), in_ready drops after the 256th beat, overflow=1, no FILL writes, core released after RST_HOLD cycles.
- In RUN, pulse start and load 3 words -> core_rst=1 next cycle; 3 writes then 253 NOP writes; rst asserted mid-FILL -> reset values next edge, no further mem_we.
- With PROG_LOADER_CHECKSUM_EN: words 32'h1, 32'h2, 32'h4 with exp_sum=32'h7 -> RUN; with exp_sum=32'h6 -> sum_err=1, core_rst stays high for at least 50 cycles until start.
